plru_fill_ctrl: RTL
===================

// Module: plru_fill_ctrl
// PURPOSE
//  Miss-fill controller on the consuming end of the pseudoLRU interface. It
//  reads the PLRU victim, picks the way to replace, writes back a dirty victim,
//  fetches the missing line, installs it, then feeds the installed way back
//  into pseudoLRU (load/in) as an access. Sits between the L1 cache datapath
//  and the memory-side port.
// PARAMETERS
//  WAYS_LOG2  3    log2 of associativity; ways = 2**WAYS_LOG2; matches pseudoLRU param
//  ADDR_W     32   byte-address width
//  LINE_W     256  cache line width in bits; OFFSET_W = $clog2(LINE_W/8)
// PORTS
//  clk          in   1                clock, all state on rising edge
//  rst_n        in   1                asynchronous, active-low reset
//  miss_req     in   1                cache miss pending; held high until miss_done
//  miss_addr    in   ADDR_W           byte address of missing access, stable while miss_req
//  plru_victim  in   WAYS_LOG2        pseudoLRU out (least-recently-used way of set)
//  way_valid    in   2**WAYS_LOG2     valid bits of indexed set
//  way_dirty    in   2**WAYS_LOG2     dirty bits of indexed set
//  wb_addr      in   ADDR_W           line address of the way on sel_way (datapath lookup)
//  wb_data      in   LINE_W           line data of the way on sel_way
//  sel_way      out  WAYS_LOG2        latched replacement way
//  mem_read     out  1                line read request
//  mem_write    out  1                line write-back request
//  mem_addr     out  ADDR_W           line-aligned memory address
//  mem_wdata    out  LINE_W           write-back data
//  mem_rdata    in   LINE_W           read data, valid with mem_resp
//  mem_resp     in   1                one-cycle completion of current mem request
//  fill_we      out  1                write fill_data into way fill_way; clear dirty, set valid
//  fill_way     out  WAYS_LOG2        = sel_way
//  fill_data    out  LINE_W           captured line
//  plru_load    out  1                pseudoLRU load strobe
//  plru_in      out  WAYS_LOG2        way reported as accessed (= sel_way)
//  miss_done    out  1                one-cycle completion pulse
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE; every output, sel_way and the fill
//    buffer clear to 0 immediately. An in-flight miss is abandoned: no fill_we
//    or plru_load follows.
//  - FSM: IDLE, WRITEBACK, READ, INSTALL, DONE. miss_req sampled only in IDLE.
//  - IDLE, miss_req=1: choose way. If any way_valid bit is 0, take the
//    lowest-index invalid way; else take plru_victim. Latch way into sel_way
//    and latch line address = miss_addr with low OFFSET_W bits zeroed. Go to
//    WRITEBACK if the chosen way is valid and dirty, else READ.
//  - WRITEBACK: mem_write=1, mem_addr=wb_addr (low OFFSET_W bits forced 0),
//    mem_wdata=wb_data, all held stable until mem_resp. On mem_resp go to READ.
//  - READ: mem_read=1, mem_addr=latched line address, held stable. On mem_resp
//    capture mem_rdata into fill_data and go to INSTALL. mem_read and mem_write
//    are never high together.
//  - INSTALL (exactly 1 cycle): fill_we=1, fill_way=sel_way, plru_load=1,
//    plru_in=sel_way. Go to DONE.
//  - DONE (exactly 1 cycle): miss_done=1, then IDLE. The requester drops
//    miss_req on the edge that ends DONE. miss_req still high in the next IDLE
//    cycle starts a new miss.
//  - fill_we, plru_load and miss_done are 0 outside INSTALL/DONE. plru_load is
//    never asserted except on a completed fill.
//  - mem_resp outside WRITEBACK/READ is ignored.
//  - Latency from the IDLE edge that samples miss_req, with mem_resp in the
//    first request cycle: clean miss, miss_done 3 cycles later; dirty, 4 later.
//    Each extra memory wait cycle adds 1.
// TESTING
//  1 Reset: rst_n=0 mid-clock -> all outputs 0 without waiting for a clock
//    edge; after release stays IDLE with miss_req=0.
//  2 way_valid=8'hFB, plru_victim=5, miss -> sel_way=2, no mem_write, fill_way=2,
//    plru_in=2.
//  3 way_valid=8'hFF, way_dirty=0, plru_victim=6, zero-wait mem -> mem_read one
//    cycle, fill_we+plru_load one cycle with way 6, miss_done 3 cycles after
//    the sampling edge.
//  4 way_valid=8'hFF, way_dirty=8'h08, plru_victim=3, mem_resp after 4 cycles ->
//    mem_write with wb_addr/wb_data held 4 cycles, then mem_read, fill_data==mem_rdata.
//  5 miss_addr=32'h1234_567F -> mem_addr=32'h1234_5660. mem_resp pulsed in IDLE
//    -> no state change.
//  6 rst_n low during READ -> no fill_we/plru_load afterwards; next miss
//    completes normally. Then 1000 random misses with behavioural plru model
//    mirroring plru_in -> plru_victim matches at every miss.

Source files
------------

// File: rtl/plru_fill_if.sv
// Bundle between the miss-fill controller and its cache datapath / memory port.
// master = controller side, slave = datapath/memory/pseudoLRU side.
interface plru_fill_if #(
  parameter int WAYS_LOG2 = 3,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256
);
  localparam int WAYS = 2**WAYS_LOG2;

  logic                 miss_req;
  logic [ADDR_W-1:0]    miss_addr;
  logic [WAYS_LOG2-1:0] plru_victim;
  logic [WAYS-1:0]      way_valid;
  logic [WAYS-1:0]      way_dirty;
  logic [ADDR_W-1:0]    wb_addr;
  logic [LINE_W-1:0]    wb_data;
  logic [WAYS_LOG2-1:0] sel_way;
  logic                 mem_read;
  logic                 mem_write;
  logic [ADDR_W-1:0]    mem_addr;
  logic [LINE_W-1:0]    mem_wdata;
  logic [LINE_W-1:0]    mem_rdata;
  logic                 mem_resp;
  logic                 fill_we;
  logic [WAYS_LOG2-1:0] fill_way;
  logic [LINE_W-1:0]    fill_data;
  logic                 plru_load;
  logic [WAYS_LOG2-1:0] plru_in;
  logic                 miss_done;

  modport master (
    input  miss_req, miss_addr, plru_victim, way_valid, way_dirty,
           wb_addr, wb_data, mem_rdata, mem_resp,
    output sel_way, mem_read, mem_write, mem_addr, mem_wdata,
           fill_we, fill_way, fill_data, plru_load, plru_in, miss_done
  );

  modport slave (
    output miss_req, miss_addr, plru_victim, way_valid, way_dirty,
           wb_addr, wb_data, mem_rdata, mem_resp,
    input  sel_way, mem_read, mem_write, mem_addr, mem_wdata,
           fill_we, fill_way, fill_data, plru_load, plru_in, miss_done
  );
endinterface

// File: rtl/plru_fill_ctrl.sv
// Miss-fill controller: picks a replacement way, writes back a dirty victim,
// fetches and installs the missing line, then reports the way to pseudoLRU.
module plru_fill_ctrl #(
  parameter int WAYS_LOG2 = 3,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256
) (
  input logic         clk,
  input logic         rst_n,
  plru_fill_if.master bus
);
  localparam int WAYS     = 2**WAYS_LOG2;
  localparam int OFFSET_W = $clog2(LINE_W/8);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WB      = 3'd1;
  localparam logic [2:0] S_READ    = 3'd2;
  localparam logic [2:0] S_INSTALL = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } mem_req_t;

  logic [2:0]           state;
  logic [WAYS_LOG2-1:0] sel_way;
  logic [ADDR_W-1:0]    line_addr;
  logic [LINE_W-1:0]    fill_buf;
  logic [WAYS_LOG2-1:0] pick_way;
  logic                 any_invalid;
  logic                 pick_dirty;
  mem_req_t             req;

  // Invalid ways fill first (lowest index wins); otherwise evict the PLRU victim.
  always_comb begin
    pick_way    = bus.plru_victim;
    any_invalid = 1'b0;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (!bus.way_valid[i]) begin
        pick_way    = WAYS_LOG2'(i);
        any_invalid = 1'b1;
      end
    end
    pick_dirty = !any_invalid && bus.way_dirty[bus.plru_victim];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sel_way   <= '0;
      line_addr <= '0;
      fill_buf  <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.miss_req) begin
          sel_way   <= pick_way;
          line_addr <= bus.miss_addr & LINE_MASK;
          state     <= pick_dirty ? S_WB : S_READ;
        end
        S_WB:   if (bus.mem_resp) state <= S_READ;
        S_READ: if (bus.mem_resp) begin
          fill_buf <= bus.mem_rdata;
          state    <= S_INSTALL;
        end
        S_INSTALL: state <= S_DONE;
        S_DONE:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Memory request is a pure decode of state so reset clears it without a clock.
  always_comb begin
    req = '0;
    case (state)
      S_WB: begin
        req.wr    = 1'b1;
        req.addr  = bus.wb_addr & LINE_MASK;
        req.wdata = bus.wb_data;
      end
      S_READ: begin
        req.rd   = 1'b1;
        req.addr = line_addr;
      end
      default: req = '0;
    endcase
  end

  assign bus.mem_read  = req.rd;
  assign bus.mem_write = req.wr;
  assign bus.mem_addr  = req.addr;
  assign bus.mem_wdata = req.wdata;
  assign bus.sel_way   = sel_way;
  assign bus.fill_we   = (state == S_INSTALL);
  assign bus.fill_way  = sel_way;
  assign bus.fill_data = fill_buf;
  assign bus.plru_load = (state == S_INSTALL);
  assign bus.plru_in   = sel_way;
  assign bus.miss_done = (state == S_DONE);
endmodule
